// File: rtl/fifo_read_ctrl.sv
// FIFO read-side control: pop arbitration, read pointer, occupancy, flags.
// Define FIFO_ERR_STICKY_EN to hold underflow/overflow until reset.
module fifo_read_ctrl #(
    parameter int MEM_SIZE  = 4,
    parameter int WORD_SIZE = 6,
    parameter int PTR       = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fifo_rd,
    input  logic                 push,
    input  logic [WORD_SIZE-1:0] mem_rd_data,
    input  logic [PTR-1:0]       thr_high,
    input  logic [PTR-1:0]       thr_low,
    output logic [PTR-1:0]       rd_ptr,
    output logic                 pop,
    output logic [WORD_SIZE-1:0] data_out,
    output logic                 valid_out,
    output logic [PTR-1:0]       count,
    output logic                 fifo_full,
    output logic                 fifo_empty,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic                 underflow,
    output logic                 overflow
);

    localparam logic [PTR-1:0] FULL_CNT = PTR'(MEM_SIZE);
    localparam logic [PTR-1:0] LAST_PTR = PTR'(MEM_SIZE - 1);
    localparam logic [PTR-1:0] ONE      = PTR'(1);

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t         state;
    logic [PTR-1:0] thr_high_lat;
    logic [PTR-1:0] thr_low_lat;
    logic [PTR-1:0] count_next;
    logic           underflow_evt;
    logic           overflow_evt;

    // Flags decode from the registered occupancy only.
    assign fifo_full    = (count == FULL_CNT);
    assign fifo_empty   = (count == '0);
    assign almost_full  = (count >= thr_high_lat);
    assign almost_empty = (count <= thr_low_lat);

    // A pop needs stored data; a same-cycle push is never bypassed.
    assign pop = fifo_rd & ~fifo_empty & (state != INIT) & ~reset;

    assign underflow_evt = fifo_rd & fifo_empty;
    assign overflow_evt  = push & fifo_full & ~pop;

    // Next occupancy: simultaneous push/pop cancel, saturate at full.
    always_comb begin
        count_next = count;
        if (push && !pop && count != FULL_CNT) begin
            count_next = count + ONE;
        end else if (pop && !push) begin
            count_next = count - ONE;
        end
    end

    // Control FSM; thresholds are captured only while in INIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= INIT;
            thr_high_lat <= LAST_PTR;
            thr_low_lat  <= ONE;
        end else begin
            unique case (state)
                INIT: begin
                    thr_high_lat <= thr_high;
                    thr_low_lat  <= thr_low;
                    state        <= IDLE;
                end
                IDLE: begin
                    if (push) begin
                        state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (count_next == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Occupancy, read pointer and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            count     <= '0;
            rd_ptr    <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
        end else begin
            count     <= count_next;
            valid_out <= pop;
            if (pop) begin
                data_out <= mem_rd_data;
                if (rd_ptr == LAST_PTR) begin
                    rd_ptr <= '0;
                end else begin
                    rd_ptr <= rd_ptr + ONE;
                end
            end
        end
    end

`ifdef FIFO_ERR_STICKY_EN
    // Error flags latch on the first offending event until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            underflow <= underflow | underflow_evt;
            overflow  <= overflow | overflow_evt;
        end
    end
`else
    // Error flags pulse for one cycle after each offending event.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            underflow <= underflow_evt;
            overflow  <= overflow_evt;
        end
    end
`endif

    // Occupancy must stay within the physical depth.
    a_count_range: assert property (
        @(posedge clk) disable iff (reset) count <= FULL_CNT
    );

    // A pop is only ever granted against stored data.
    a_pop_nonempty: assert property (
        @(posedge clk) disable iff (reset) pop |-> !fifo_empty
    );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Directed bench for fifo_read_ctrl with a data scoreboard on valid_out.
// Error-flag expectations follow FIFO_ERR_STICKY_EN when it is defined.
module tb_fifo_read_ctrl;

`ifdef FIFO_ERR_STICKY_EN
    localparam logic STICKY = 1'b1;
`else
    localparam logic STICKY = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       fifo_rd;
    logic       push;
    logic [5:0] mem_rd_data;
    logic [2:0] thr_high;
    logic [2:0] thr_low;
    logic [2:0] rd_ptr;
    logic       pop;
    logic [5:0] data_out;
    logic       valid_out;
    logic [2:0] count;
    logic       fifo_full;
    logic       fifo_empty;
    logic       almost_full;
    logic       almost_empty;
    logic       underflow;
    logic       overflow;

    logic [5:0] mem [0:7];
    int         wp;
    logic [5:0] model_q[$];
    logic [5:0] exp_q[$];
    int         n_checks;
    int         n_fail;

    fifo_read_ctrl #(
        .MEM_SIZE(4),
        .WORD_SIZE(6),
        .PTR(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .fifo_rd(fifo_rd),
        .push(push),
        .mem_rd_data(mem_rd_data),
        .thr_high(thr_high),
        .thr_low(thr_low),
        .rd_ptr(rd_ptr),
        .pop(pop),
        .data_out(data_out),
        .valid_out(valid_out),
        .count(count),
        .fifo_full(fifo_full),
        .fifo_empty(fifo_empty),
        .almost_full(almost_full),
        .almost_empty(almost_empty),
        .underflow(underflow),
        .overflow(overflow)
    );

    assign mem_rd_data = mem[rd_ptr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One bus cycle: drive, check the combinational pop, clock, update model.
    task automatic cyc(input logic p, input logic r, input logic exp_pop,
                       input logic wr, input logic [5:0] w);
        push    = p;
        fifo_rd = r;
        #1;
        check("pop", int'(pop), int'(exp_pop));
        if (exp_pop && model_q.size() > 0) exp_q.push_back(model_q.pop_front());
        if (wr) model_q.push_back(w);
        @(posedge clk);
        #1;
        if (wr) begin
            mem[wp] = w;
            wp = (wp + 1) % 4;
        end
        push    = 1'b0;
        fifo_rd = 1'b0;
    endtask

    // Monitor: every valid_out must match the oldest expected word.
    always @(negedge clk) begin
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                check("data_out_sb", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    logic [5:0] words [4];
    int exp_af [4];
    int exp_fl [4];
    int exp_ae [4];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wp       = 0;
        for (int i = 0; i < 8; i++) mem[i] = 6'h00;
        words  = '{6'h2A, 6'h15, 6'h3C, 6'h07};
        exp_af = '{0, 0, 1, 1};
        exp_fl = '{0, 0, 0, 1};
        exp_ae = '{1, 0, 0, 0};

        reset    = 1'b1;
        push     = 1'b0;
        fifo_rd  = 1'b1;
        thr_high = 3'd3;
        thr_low  = 3'd1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", int'(count), 0);
        check("rst_rd_ptr", int'(rd_ptr), 0);
        check("rst_valid", int'(valid_out), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_empty", int'(fifo_empty), 1);
        check("rst_aempty", int'(almost_empty), 1);
        check("rst_full", int'(fifo_full), 0);
        check("rst_afull", int'(almost_full), 0);
        check("rst_pop", int'(pop), 0);
        check("rst_underflow", int'(underflow), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_state", int'(dut.state), 0);

        fifo_rd = 1'b0;
        reset   = 1'b0;
        @(posedge clk);
        #1;
        check("init_to_idle", int'(dut.state), 1);
        thr_high = 3'd1;
        thr_low  = 3'd3;

        // Fill to full
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, words[i]);
            check("fill_count", int'(count), i + 1);
            check("fill_afull", int'(almost_full), exp_af[i]);
            check("fill_full", int'(fifo_full), exp_fl[i]);
            check("fill_aempty", int'(almost_empty), exp_ae[i]);
            check("fill_state", int'(dut.state), 2);
        end

        // Single read from full
        check("pre_rd_ptr", int'(rd_ptr), 0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 6'h00);
        check("rd_ptr_1", int'(rd_ptr), 1);
        check("rd_count", int'(count), 3);
        check("rd_valid", int'(valid_out), 1);
        check("rd_data", int'(data_out), 'h2A);
        check("rd_full", int'(fifo_full), 0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        check("idle_valid", int'(valid_out), 0);
        check("hold_data", int'(data_out), 'h2A);

        // Drain to empty
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 6'h00);
            check("drain_count", int'(count), 2 - i);
        end
        check("drain_rd_ptr", int'(rd_ptr), 0);
        check("drain_empty", int'(fifo_empty), 1);
        check("drain_state", int'(dut.state), 1);
        check("drain_uf", int'(underflow), 0);

        // Round trips with pointer wrap
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1, 6'(i + 1));
            check("rt_state_act", int'(dut.state), 2);
            check("rt_count1", int'(count), 1);
            cyc(1'b0, 1'b1, 1'b1, 1'b0, 6'h00);
            check("rt_rd_ptr", int'(rd_ptr), (i + 1) % 4);
            check("rt_count0", int'(count), 0);
            check("rt_state_idle", int'(dut.state), 1);
        end

        // Push and read together on empty
        cyc(1'b1, 1'b1, 1'b0, 1'b1, 6'h11);
        check("uf_count", int'(count), 1);
        check("uf_set", int'(underflow), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 6'h12);
        check("uf_after", int'(underflow), int'(STICKY));
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 6'h13);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 6'h14);
        check("refill_full", int'(fifo_full), 1);

        // Push and read together on full
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 6'h15);
        check("pp_count", int'(count), 4);
        check("pp_overflow", int'(overflow), 0);
        check("pp_rd_ptr", int'(rd_ptr), 2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 6'h16);
        check("of_set", int'(overflow), 1);
        check("of_count", int'(count), 4);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 6'h00);
        check("of_after", int'(overflow), int'(STICKY));
        check("uf_late", int'(underflow), int'(STICKY));

        // Reach count 2 with rd_ptr off zero, then reset mid-stream
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 6'h00);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 6'h00);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 6'h17);
        check("mid_count", int'(count), 2);
        check("mid_rd_ptr", int'(rd_ptr), 1);
        reset   = 1'b1;
        push    = 1'b1;
        fifo_rd = 1'b1;
        #1;
        check("rst_pop_gate", int'(pop), 0);
        @(posedge clk);
        #1;
        check("mrst_count", int'(count), 0);
        check("mrst_rd_ptr", int'(rd_ptr), 0);
        check("mrst_valid", int'(valid_out), 0);
        check("mrst_empty", int'(fifo_empty), 1);
        check("mrst_state", int'(dut.state), 0);
        check("mrst_uf", int'(underflow), 0);
        check("mrst_of", int'(overflow), 0);
        reset   = 1'b0;
        push    = 1'b0;
        fifo_rd = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_state", int'(dut.state), 1);
        repeat (2) @(posedge clk);
        #1;
        check("sb_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
